// File: rtl/conv11_pkg.sv
// Shared definitions for the conv11 input path.
// Holds the default tile geometry and the buffer state encoding used by
// conv11_input_buf (same encoding style as the conv11 input controller).
package conv11_pkg;

   localparam int DATA_W = 8;
   localparam int CH     = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/conv11_input_buf.sv
// conv11_input_buf: packs a stream of CH channel words into one parallel
// tile register and hands it to the conv11 input controller.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   s_valid/s_data  upstream word stream
//   s_ready         buffer can take a word this cycle (state decode)
//   flush           discard the tile in progress (tile_data is kept)
//   input_ready     release pulse from the controller (tile consumed)
//   input_valid     tile in progress or complete
//   inputbuf_load   tile complete and held stable
//   tile_data       packed tile, word i at [i*DATA_W +: DATA_W]
//   word_idx        next write slot
module conv11_input_buf #(
   parameter int  DATA_W = conv11_pkg::DATA_W,
   parameter int  CH     = conv11_pkg::CH,
   localparam int CNT_W  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   input  logic [DATA_W-1:0]    s_data,
   output logic                 s_ready,
   input  logic                 flush,
   input  logic                 input_ready,
   output logic                 input_valid,
   output logic                 inputbuf_load,
   output logic [CH*DATA_W-1:0] tile_data,
   output logic [CNT_W-1:0]     word_idx
);

   import conv11_pkg::*;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CH - 1);

   buf_state_t       state_r;
   buf_state_t       state_next_s;
   logic [CNT_W-1:0] idx_next_s;
   logic             accept_s;

   // Ready is a pure state decode so upstream sees it in the same cycle.
   always_comb begin
      case (state_r)
         EMPTY:   s_ready = 1'b1;
         FILL:    s_ready = 1'b1;
         FULL:    s_ready = 1'b0;
         default: s_ready = 1'b0;
      endcase
   end

   // Accept strobe for the upstream handshake.
   always_comb begin
      accept_s = s_valid && s_ready;
   end

   // Next state and next write index; flush overrides everything else.
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = word_idx;
      if (flush) begin
         state_next_s = EMPTY;
         idx_next_s   = '0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  if (CH == 1) begin
                     state_next_s = FULL;
                     idx_next_s   = '0;
                  end else begin
                     state_next_s = FILL;
                     idx_next_s   = CNT_W'(1);
                  end
               end else begin
                  state_next_s = EMPTY;
               end
            end
            FILL: begin
               if (accept_s) begin
                  if (word_idx == LAST_IDX) begin
                     state_next_s = FULL;
                     idx_next_s   = '0;
                  end else begin
                     state_next_s = FILL;
                     idx_next_s   = word_idx + CNT_W'(1);
                  end
               end else begin
                  state_next_s = FILL;
               end
            end
            FULL: begin
               // Words offered here are not taken; s_ready is low.
               if (input_ready) begin
                  state_next_s = EMPTY;
               end else begin
                  state_next_s = FULL;
               end
            end
            default: begin
               state_next_s = EMPTY;
               idx_next_s   = '0;
            end
         endcase
      end
   end

   // State, index, handshake outputs (registered from next state) and tile storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= EMPTY;
         word_idx      <= '0;
         input_valid   <= 1'b0;
         inputbuf_load <= 1'b0;
         tile_data     <= '0;
      end else begin
         state_r       <= state_next_s;
         word_idx      <= idx_next_s;
         input_valid   <= (state_next_s == FILL) || (state_next_s == FULL);
         inputbuf_load <= (state_next_s == FULL);
         // A flushed word is dropped; the old tile contents stay in place.
         if (accept_s && !flush) begin
            tile_data[int'(word_idx) * DATA_W +: DATA_W] <= s_data;
         end
      end
   end

endmodule

// File: tb/tb_conv11_input_buf.sv
// Self-checking bench for conv11_input_buf: a CH=16 and a CH=1 instance share
// the same stimulus and are compared every cycle against word-count models.
module tb_conv11_input_buf;

   localparam int DW = 8;
   localparam int CH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, s_valid, flush, input_ready;
   logic [DW-1:0]    s_data;
   logic             s_ready, input_valid, inputbuf_load;
   logic [CH*DW-1:0] tile_data;
   logic [3:0]       word_idx;
   logic             s_ready1, input_valid1, inputbuf_load1;
   logic [DW-1:0]    tile_data1;
   logic [0:0]       word_idx1;

   conv11_input_buf #(.DATA_W(DW), .CH(CH)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .flush(flush), .input_ready(input_ready), .input_valid(input_valid),
      .inputbuf_load(inputbuf_load), .tile_data(tile_data), .word_idx(word_idx));

   conv11_input_buf #(.DATA_W(DW), .CH(1)) u_dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
      .flush(flush), .input_ready(input_ready), .input_valid(input_valid1),
      .inputbuf_load(inputbuf_load1), .tile_data(tile_data1), .word_idx(word_idx1));

   int n_checks = 0;
   int n_errors = 0;

   // Reference: number of words collected, whether a tile is held, tile image.
   int               m_count = 0;
   bit               m_full  = 1'b0;
   logic [CH*DW-1:0] m_tile  = '0;
   bit               m1_full = 1'b0;
   logic [DW-1:0]    m1_tile = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit sv, input bit fl, input bit ir,
                               input logic [DW-1:0] d);
      if (r) begin
         m_count = 0; m_full = 1'b0; m_tile = '0;
         m1_full = 1'b0; m1_tile = '0;
      end else begin
         if (fl) begin
            m_count = 0; m_full = 1'b0;
         end else if (m_full) begin
            if (ir) m_full = 1'b0;
         end else if (sv) begin
            m_tile[m_count*DW +: DW] = d;
            m_count++;
            if (m_count == CH) begin
               m_full = 1'b1; m_count = 0;
            end
         end
         if (fl) begin
            m1_full = 1'b0;
         end else if (m1_full) begin
            if (ir) m1_full = 1'b0;
         end else if (sv) begin
            m1_tile = d; m1_full = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      check("s_ready",        128'(s_ready),        128'(!m_full));
      check("input_valid",    128'(input_valid),    128'(m_full || (m_count != 0)));
      check("inputbuf_load",  128'(inputbuf_load),  128'(m_full));
      check("word_idx",       128'(word_idx),       128'(m_count));
      check("tile_data",      128'(tile_data),      128'(m_tile));
      check("ch1_s_ready",    128'(s_ready1),       128'(!m1_full));
      check("ch1_valid",      128'(input_valid1),   128'(m1_full));
      check("ch1_load",       128'(inputbuf_load1), 128'(m1_full));
      check("ch1_word_idx",   128'(word_idx1),      128'(0));
      check("ch1_tile_data",  128'(tile_data1),     128'(m1_tile));
   endtask

   // Drive one cycle of inputs, clock it, update the model, then compare.
   task automatic step(input bit r, input bit sv, input bit fl, input bit ir,
                       input logic [DW-1:0] d);
      rst = r; s_valid = sv; flush = fl; input_ready = ir; s_data = d;
      @(posedge clk);
      model_update(r, sv, fl, ir, d);
      #1;
      check_all();
   endtask

   initial begin
      int  cst;
      bit  iv_s, ld_s, ir_s;
      int  rises, pulses, last_rise;
      rst = 1'b1; s_valid = 1'b0; flush = 1'b0; input_ready = 1'b0; s_data = '0;

      // Reset, then 16 back-to-back words.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
      check("t1_load",   128'(inputbuf_load),    128'(1));
      check("t1_word0",  128'(tile_data[7:0]),   128'(8'h01));
      check("t1_word15", 128'(tile_data[127:120]), 128'(8'h10));
      check("t1_ready",  128'(s_ready),          128'(0));

      // Hold with words offered, then release while 0xAA is offered.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA);
      check("rel_empty", 128'(input_valid), 128'(0));
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
      check("rel_slot0", 128'(tile_data[7:0]), 128'(8'hAA));
      check("rel_idx",   128'(word_idx),       128'(1));

      // Gapped stream after words 5 and 12.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
         if (i == 5 || i == 12) begin
            for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
         end
      end
      check("gap_load",  128'(inputbuf_load),      128'(1));
      check("gap_word4", 128'(tile_data[39:32]),   128'(8'h05));
      // Reset while holding a full tile.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // Flush after 7 words together with 0x55, then a clean tile.
      for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
      check("flush_idx", 128'(word_idx), 128'(0));
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      check("flush_word0", 128'(tile_data[7:0]), 128'(8'h81));
      check("flush_load",  128'(inputbuf_load),  128'(1));

      // Reset in the middle of a fill.
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);

      // Behavioural controller: IDLE(0)->WAIT(1) on input_valid,
      // WAIT->COMPUTE(2) on inputbuf_load, pulse input_ready in COMPUTE.
      cst = 0; rises = 0; pulses = 0; last_rise = -1;
      for (int c = 0; c < 56; c++) begin
         iv_s = input_valid; ld_s = inputbuf_load; ir_s = (cst == 2);
         if (ir_s) begin
            pulses++;
            check("ctrl_ready_in_full", 128'(ld_s), 128'(1));
         end
         step(1'b0, 1'b1, 1'b0, ir_s, 8'($urandom));
         case (cst)
            0:       if (iv_s) cst = 1;
            1:       if (ld_s) cst = 2;
            default: cst = 0;
         endcase
         if (cst == 1) check("ctrl_wait_valid", 128'(input_valid), 128'(1));
         if (inputbuf_load && !ld_s) begin
            if (last_rise >= 0) check("tile_period", 128'(c - last_rise), 128'(18));
            last_rise = c;
            rises++;
         end
      end
      check("ctrl_pulses", 128'(pulses), 128'(3));
      check("ctrl_tiles",  128'(rises),  128'(3));

      // Randomized traffic with occasional flush, release and reset.
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
